l1_dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache controller. It serves 32-bit word requests from the multicycle OTTER core's memory stage. On a miss it issues whole 256-bit line transfers through the cacheline adaptor, which sits directly downstream and moves each line to or from main memory as eight 32-bit words. The block holds the tag, valid and dirty state, owns line data storage, and keeps hit/miss performance counters.

---
 rtl/l1_dcache_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache
// controller for 32-bit word requests. Misses move whole 256-bit lines to or
// from the downstream cacheline adaptor.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_re / cpu_we       word read / write request, held until cpu_valid
//   cpu_addr, cpu_wdata   byte address (bits [1:0] ignored), write data
//   cpu_strobe            write byte enables (bit n -> byte lane n)
//   cpu_rdata, cpu_valid  registered read data, one-cycle completion pulse
//   line_read/line_write  fill / writeback request to the adaptor
//   line_valid            adaptor completion pulse
//   line_addr             registered 32-byte-aligned line address
//   line_rdata/line_wdata fill data in / registered writeback data out
//   hit_count/miss_count  saturating performance counters
module l1_dcache_ctrl #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_re,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_strobe,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_valid,
  output logic         line_read,
  output logic         line_write,
  input  logic         line_valid,
  output logic [31:0]  line_addr,
  input  logic [255:0] line_rdata,
  output logic [255:0] line_wdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 27 - IDX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, RESP} state_e;

  state_e         state_q, state_d;
  logic [31:2]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     strb_q, strb_d;
  logic           we_q, we_d;
  logic           refilled_q, refilled_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    line_addr_q, line_addr_d;
  logic [255:0]   line_wdata_q, line_wdata_d;
  logic [31:0]    hit_q, hit_d;
  logic [31:0]    miss_q, miss_d;

  logic [255:0]   data_q [NUM_LINES];
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, dirty_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       off;
  logic             hit;
  logic [255:0]     cur_line, merged_line;
  logic [31:0]      cur_word, merged_word;
  logic             fill_en, wr_en;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign idx      = addr_q[4+IDX_W:5];
  assign req_tag  = addr_q[31:5+IDX_W];
  assign off      = addr_q[4:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign cur_line = data_q[idx];
  assign cur_word = cur_line[{off, 5'b0} +: 32];

  always_comb begin
    merged_word = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb_q[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
    merged_line = cur_line;
    merged_line[{off, 5'b0} +: 32] = merged_word;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    we_d         = we_q;
    refilled_d   = refilled_q;
    rdata_d      = rdata_q;
    line_addr_d  = line_addr_q;
    line_wdata_d = line_wdata_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    fill_en      = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_we || cpu_re) begin
          addr_d     = cpu_addr[31:2];
          wdata_d    = cpu_wdata;
          strb_d     = cpu_strobe;
          we_d       = cpu_we;
          refilled_d = 1'b0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          if (we_q) wr_en = 1'b1;
          else      rdata_d = cur_word;
          // The post-refill pass always hits; only first-pass hits count.
          if (!refilled_q && hit_q != '1) hit_d = hit_q + 32'd1;
          state_d = RESP;
        end else begin
          if (miss_q != '1) miss_d = miss_q + 32'd1;
          if (valid_q[idx] && dirty_q[idx]) begin
            line_addr_d  = {tag_q[idx], idx, 5'b0};
            line_wdata_d = cur_line;
            state_d      = WRITEBACK;
          end else begin
            line_addr_d = {req_tag, idx, 5'b0};
            state_d     = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (line_valid) begin
          line_addr_d = {req_tag, idx, 5'b0};
          state_d     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (line_valid) begin
          fill_en    = 1'b1;
          refilled_d = 1'b1;
          state_d    = COMPARE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      we_q         <= 1'b0;
      refilled_q   <= 1'b0;
      rdata_q      <= '0;
      line_addr_q  <= '0;
      line_wdata_q <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      we_q         <= we_d;
      refilled_q   <= refilled_d;
      rdata_q      <= rdata_d;
      line_addr_q  <= line_addr_d;
      line_wdata_q <= line_wdata_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_en) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Line data and tags are not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= line_rdata;
      tag_q[idx]  <= req_tag;
    end else if (wr_en) begin
      data_q[idx] <= merged_line;
    end
  end

  assign cpu_valid  = (state_q == RESP);
  assign line_read  = (state_q == ALLOCATE);
  assign line_write = (state_q == WRITEBACK);
  assign cpu_rdata  = rdata_q;
  assign line_addr  = line_addr_q;
  assign line_wdata = line_wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl: a reference cache model predicts
// CPU responses and line transfers into queues; monitors compare DUT outputs.
module tb_l1_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_re, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_strobe;
  logic [31:0]  cpu_rdata;
  logic         cpu_valid, line_read, line_write, line_valid;
  logic [31:0]  line_addr;
  logic [255:0] line_rdata, line_wdata;
  logic [31:0]  hit_count, miss_count;

  l1_dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_strobe(cpu_strobe),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .line_read(line_read),
    .line_write(line_write), .line_valid(line_valid), .line_addr(line_addr),
    .line_rdata(line_rdata), .line_wdata(line_wdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic [31:0] hits; logic [31:0] misses; } resp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } xfer_t;

  resp_t exp_q[$];
  xfer_t xfer_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int fixed_delay = 0;

  // Main memory: 64 lines (addresses below 0x800)
  logic [255:0] mem [64];
  // Reference cache: 16 sets
  bit           c_valid [16];
  bit           c_dirty [16];
  logic [22:0]  c_tag   [16];
  logic [255:0] c_line  [16];
  logic [31:0]  m_hits, m_misses, m_rdata;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      c_valid[i] = 0;
      c_dirty[i] = 0;
    end
    m_hits = 0; m_misses = 0; m_rdata = 0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Predict the outcome of one request and queue expected transfers/response.
  task automatic model_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output bit was_hit);
    int          idx;
    int          off;
    logic [22:0] tag;
    logic [31:0] va;
    xfer_t       x;
    resp_t       r;
    idx = int'(addr[8:5]);
    off = int'(addr[4:2]);
    tag = addr[31:9];
    was_hit = c_valid[idx] && (c_tag[idx] == tag);
    if (!was_hit) begin
      m_misses = sat_inc(m_misses);
      if (c_valid[idx] && c_dirty[idx]) begin
        va = {c_tag[idx], addr[8:5], 5'b0};
        x.wr = 1; x.addr = va; x.data = c_line[idx];
        xfer_q.push_back(x);
        mem[va[10:5]] = c_line[idx];
      end
      x.wr = 0; x.addr = {addr[31:5], 5'b0}; x.data = '0;
      xfer_q.push_back(x);
      c_line[idx]  = mem[addr[10:5]];
      c_valid[idx] = 1;
      c_dirty[idx] = 0;
      c_tag[idx]   = tag;
    end else begin
      m_hits = sat_inc(m_hits);
    end
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) c_line[idx][off*32 + b*8 +: 8] = wd[b*8 +: 8];
      c_dirty[idx] = 1;
    end else begin
      m_rdata = c_line[idx][off*32 +: 32];
    end
    r.rdata = m_rdata; r.hits = m_hits; r.misses = m_misses;
    exp_q.push_back(r);
  endtask

  task automatic do_op(input bit re, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    bit h;
    int n;
    bit got;
    model_op(we, addr, wd, strb, h);
    @(negedge clk);
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_strobe = strb;
    n = 0; got = 0;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (cpu_valid) got = 1;
    end
    if (!got) begin
      chk("cpu_valid_timeout", 0, 1);
      finish_run();
    end
    if (h) chk("hit_latency", n, 2);
    cpu_re = 0; cpu_we = 0;
  endtask

  // CPU response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cpu_valid", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("cpu_rdata", cpu_rdata, r.rdata);
          chk("hit_count", hit_count, r.hits);
          chk("miss_count", miss_count, r.misses);
        end
      end
    end
  end

  // Adaptor model and line-side monitor
  initial begin
    xfer_t x;
    bit    have, is_wr, aborted;
    int    d;
    line_valid = 0;
    line_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (line_read || line_write)) begin
        chk("line_req_exclusive", line_read && line_write, 0);
        have = xfer_q.size() != 0;
        if (!have) begin
          chk("unexpected_line_req", 1, 0);
        end else begin
          x = xfer_q.pop_front();
          chk("line_op_is_write", line_write, x.wr);
          chk("line_addr", line_addr, x.addr);
          if (x.wr) chk("line_wdata", line_wdata, x.data);
        end
        is_wr = line_write;
        d = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 6);
        aborted = 0;
        for (int i = 1; i < d; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1;
            break;
          end
          if (have) chk("line_addr_stable", line_addr, x.addr);
        end
        if (!aborted) begin
          line_valid = 1;
          line_rdata = mem[line_addr[10:5]];
          @(negedge clk);
          line_valid = 0;
          if (rst_n) chk("line_req_drop", is_wr ? line_write : line_read, 0);
        end
      end
    end
  end

  initial begin
    int          n;
    bit          h;
    logic [31:0] a;
    int          r;
    rst_n = 0; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_strobe = '0;
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 8; w++) mem[l][w*32 +: 32] = $urandom;
    for (int w = 0; w < 8; w++) mem[8][w*32 +: 32] = 32'hA0 + w;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_cpu_valid", cpu_valid, 0);
    chk("rst_line_read", line_read, 0);
    chk("rst_line_write", line_write, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_line_addr", line_addr, 0);
    chk("rst_line_wdata", line_wdata, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);

    // Directed scenarios
    fixed_delay = 12;
    do_op(1, 0, 32'h100, 0, 0);
    fixed_delay = 0;
    chk("tp_first_read", cpu_rdata, 32'hA0);
    chk("tp_first_miss", miss_count, 1);
    chk("tp_first_hit", hit_count, 0);
    do_op(1, 0, 32'h104, 0, 0);
    chk("tp_read_hit", cpu_rdata, 32'hA1);
    do_op(0, 1, 32'h108, 32'hAABBCCDD, 4'b0011);
    do_op(1, 0, 32'h108, 0, 0);
    chk("tp_masked_write", cpu_rdata, 32'h0000CCDD);
    do_op(1, 0, 32'h300, 0, 0);
    do_op(1, 1, 32'h300, 32'h12345678, 4'hF);
    do_op(1, 0, 32'h300, 0, 0);
    chk("tp_simultaneous", cpu_rdata, 32'h12345678);

    // Reset while a fill is outstanding
    model_op(0, 32'h040, 0, 0, h);
    fixed_delay = 30;
    @(negedge clk);
    cpu_re = 1; cpu_addr = 32'h040;
    n = 0;
    while (n < 50 && !line_read) begin
      @(negedge clk);
      n++;
    end
    if (!line_read) begin
      chk("fill_request_timeout", 0, 1);
      finish_run();
    end
    #2 rst_n = 0;
    #1;
    chk("rst_async_line_read", line_read, 0);
    chk("rst_async_cpu_valid", cpu_valid, 0);
    chk("rst_async_miss_count", miss_count, 0);
    cpu_re = 0;
    exp_q.delete();
    xfer_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    fixed_delay = 0;
    do_op(1, 0, 32'h040, 0, 0);
    chk("tp_reset_remiss", miss_count, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a = {21'b0, 6'($urandom_range(0, 39)), 3'($urandom), 2'($urandom)};
      r = $urandom_range(0, 3);
      if (r == 0)      do_op(0, 1, a, $urandom, 4'($urandom));
      else if (r == 1) do_op(1, 1, a, $urandom, 4'($urandom));
      else             do_op(1, 0, a, 0, 4'($urandom));
    end
    repeat (4) @(negedge clk);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("xfer_queue_drained", xfer_q.size(), 0);
    finish_run();
  end

endmodule
